regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Multi-cycle control unit for the 10-bit processor datapath.
- Accepts one instruction at a time, latches it into an internal IR, and steps through T-states.
- Drives the register-file controls (ENW, WRA, ENR0/RDA0, ENR1/RDA1) plus the ALU and bus strobes (Ain, Gin, Gout, Extrn, FN).
- Sits between the instruction source and the register file / ALU / shared bus.

Parameters:
IW, 10, instruction width; field positions below assume 10. Other values are unsupported.

Ports:
CLKb  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Execute  input  1  request to run INSTR; level-sampled in IDLE only
INSTR  input  10  instruction: [9:8]=Rx, [7:6]=Ry, [5:4] unused, [3:0]=opcode
ENW  output  1  register-file write enable
WRA  output  2  register-file write address
ENR0  output  1  register-file read-port-0 enable
RDA0  output  2  read-port-0 address
ENR1  output  1  register-file read-port-1 enable
RDA1  output  2  read-port-1 address
Ain  output  1  latch bus/Q0 into ALU operand-A register
Gin  output  1  latch ALU result into G register
Gout  output  1  drive G onto register-file D bus
Extrn  output  1  drive external data onto D bus
FN  output  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A
Done  output  1  high during the final cycle of an instruction
Busy  output  1  high in any state other than IDLE

Behaviour:
- State: 2-bit T-state {IDLE, T1, T2, T3} plus 10-bit IR. Reset (asynchronous, active-high) forces IDLE and IR=0 immediately.
- All outputs are combinational decodes of state+IR. In IDLE and during Reset every output is 0, including WRA/RDA0/RDA1/FN=0.
- IDLE: if Execute=1 at a clock edge, IR<=INSTR and the next state is T1. Otherwise stay in IDLE. INSTR is ignored outside IDLE; IR is stable for the whole instruction.
- Opcodes:
  - 0000 LOAD, 0001 MOV, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT.
  - 1xxx is illegal.
- LOAD (1 cycle):
  - T1: Extrn=1, ENW=1, WRA=Rx, Done=1.
  - Then IDLE.
- MOV (1 cycle):
  - T1: ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, Done=1.
  - Then IDLE.
- ALU ops ADD/SUB/AND/OR/XOR/NOT (3 cycles):
  - T1: ENR0=1, RDA0=Rx, Ain=1.
  - T2: ENR1=1, RDA1=Ry, Gin=1, FN=op code (NOT->101; Ry is still read but ignored by the ALU).
  - T3: Gout=1, ENW=1, WRA=Rx, Done=1, FN held.
  - Then IDLE.
- Illegal opcode: T1 with Done=1 only, no enables asserted; then IDLE (1-cycle NOP).
- Latency: Execute sampled at edge N.
  - LOAD/MOV/illegal: Done during cycle N+1.
  - ALU ops: Done during cycle N+3.
  - ENW is never asserted before the final cycle.
- Back-to-back instructions:
  - The FSM returns to IDLE after Done. If Execute is still 1, the next instruction is accepted on the following edge.
  - Minimum gap is one IDLE cycle. Holding Execute high re-executes whatever is on INSTR.
- Bus exclusivity: at most one of Extrn, Gout, ENR0-for-bus drives the D bus in any cycle; Extrn and Gout are never both 1.
- Reset mid-instruction: the instruction is aborted, with no ENW in that or any following cycle until a new Execute. Deassertion returns to normal IDLE behaviour on the next edge.
- Rx==Ry is legal: ADD R1,R1 reads R1 in both T1 and T2 and writes R1 in T3.

Test Plan:
- Reset asserted for 2 cycles mid-T2 of ADD -> all outputs 0 asynchronously; Busy=0; no ENW until the next Execute.
- LOAD: INSTR=10_00_00_0000 (R2), Execute pulse -> next cycle Extrn=1, ENW=1, WRA=2, Done=1; following cycle Busy=0.
- MOV: INSTR=00_11_00_0001 -> one cycle with ENR0=1, RDA0=3, ENW=1, WRA=0, Done=1.
- SUB R1,R2 (INSTR=01_10_00_0011):
  - T1: ENR0=1, RDA0=1, Ain=1.
  - T2: ENR1=1, RDA1=2, Gin=1, FN=001.
  - T3: Gout=1, ENW=1, WRA=1, FN=001, Done=1.
- Execute held high with INSTR changing during T2 -> IR unchanged, and the new INSTR is executed only after an IDLE cycle.
- Illegal opcode 1010 -> single cycle with Done=1, ENW=ENR0=ENR1=Extrn=Gout=0, then IDLE.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Multi-cycle control unit for the 10-bit datapath. It latches one instruction
// into IR and steps through T-states, driving the register-file, ALU and bus
// strobes. The outputs are combinational decodes of state and IR.
module regfile_sequencer #(
    parameter int unsigned IW = 10
) (
    input  logic          CLKb,
    input  logic          Reset,
    input  logic          Execute,
    input  logic [IW-1:0] INSTR,
    output logic          ENW,
    output logic [1:0]    WRA,
    output logic          ENR0,
    output logic [1:0]    RDA0,
    output logic          ENR1,
    output logic [1:0]    RDA1,
    output logic          Ain,
    output logic          Gin,
    output logic          Gout,
    output logic          Extrn,
    output logic [2:0]    FN,
    output logic          Done,
    output logic          Busy
);

    localparam int unsigned RW  = 2;
    localparam int unsigned OPW = 4;
    localparam int unsigned FW  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_LOAD = 4'b0000;
    localparam logic [OPW-1:0] OP_MOV  = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPW-1:0] OP_AND  = 4'b0100;
    localparam logic [OPW-1:0] OP_OR   = 4'b0101;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0110;
    localparam logic [OPW-1:0] OP_NOT  = 4'b0111;

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;

    logic [RW-1:0]  rx;
    logic [RW-1:0]  ry;
    logic [OPW-1:0] op;
    logic [FW-1:0]  alu_fn;
    logic           is_alu;
    logic           unused_ir;

    assign rx        = ir_q[9:8];
    assign ry        = ir_q[7:6];
    assign op        = ir_q[3:0];
    assign unused_ir = ^ir_q[5:4];

    // Opcode to ALU function; is_alu flags the three-cycle instructions
    always_comb begin
        alu_fn = '0;
        is_alu = 1'b1;
        case (op)
            OP_ADD:  alu_fn = 3'b000;
            OP_SUB:  alu_fn = 3'b001;
            OP_AND:  alu_fn = 3'b010;
            OP_OR:   alu_fn = 3'b011;
            OP_XOR:  alu_fn = 3'b100;
            OP_NOT:  alu_fn = 3'b101;
            default: is_alu = 1'b0;
        endcase
    end

    // T-state and IR registers; reset aborts any instruction in flight
    always_ff @(posedge CLKb or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ENW     = 1'b0;
        WRA     = '0;
        ENR0    = 1'b0;
        RDA0    = '0;
        ENR1    = 1'b0;
        RDA1    = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        Extrn   = 1'b0;
        FN      = '0;
        Done    = 1'b0;
        Busy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Execute) begin
                    ir_d    = INSTR;
                    state_d = S_T1;
                end
            end

            S_T1: begin
                Busy = 1'b1;
                if (op == OP_LOAD) begin
                    Extrn   = 1'b1;
                    ENW     = 1'b1;
                    WRA     = rx;
                    Done    = 1'b1;
                    state_d = S_IDLE;
                end else if (op == OP_MOV) begin
                    ENR0    = 1'b1;
                    RDA0    = ry;
                    ENW     = 1'b1;
                    WRA     = rx;
                    Done    = 1'b1;
                    state_d = S_IDLE;
                end else if (is_alu) begin
                    ENR0    = 1'b1;
                    RDA0    = rx;
                    Ain     = 1'b1;
                    state_d = S_T2;
                end else begin
                    // Illegal opcode completes as a single-cycle NOP
                    Done    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_T2: begin
                Busy    = 1'b1;
                ENR1    = 1'b1;
                RDA1    = ry;
                Gin     = 1'b1;
                FN      = alu_fn;
                state_d = S_T3;
            end

            S_T3: begin
                Busy    = 1'b1;
                Gout    = 1'b1;
                ENW     = 1'b1;
                WRA     = rx;
                FN      = alu_fn;
                Done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: each accepted instruction is expanded into its
// list of per-cycle strobe vectors from the instruction table, and the DUT is
// compared against the head of that list every cycle.
module tb_regfile_sequencer;

    logic       CLKb = 1'b0;
    logic       Reset;
    logic       Execute;
    logic [9:0] INSTR;
    logic       ENW, ENR0, ENR1, Ain, Gin, Gout, Extrn, Done, Busy;
    logic [1:0] WRA, RDA0, RDA1;
    logic [2:0] FN;

    int total = 0;
    int bad   = 0;

    // {ENW,WRA,ENR0,RDA0,ENR1,RDA1,Ain,Gin,Gout,Extrn,FN,Done,Busy}
    typedef logic [17:0] vec_t;
    vec_t exp_q[$];
    vec_t cur;

    regfile_sequencer #(.IW(10)) dut (
        .CLKb(CLKb), .Reset(Reset), .Execute(Execute), .INSTR(INSTR),
        .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .Extrn(Extrn), .FN(FN),
        .Done(Done), .Busy(Busy)
    );

    always #5 CLKb = ~CLKb;

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic enw, input logic [1:0] wra,
                                input logic enr0, input logic [1:0] rda0,
                                input logic enr1, input logic [1:0] rda1,
                                input logic ain, input logic gin, input logic gout,
                                input logic extrn, input logic [2:0] fn,
                                input logic done);
        return {enw, wra, enr0, rda0, enr1, rda1, ain, gin, gout, extrn, fn, done, 1'b1};
    endfunction

    function automatic vec_t observed();
        return {ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout, Extrn, FN, Done, Busy};
    endfunction

    // Expand one instruction into the strobe vectors of its cycles
    task automatic expand(input logic [9:0] ins);
        logic [1:0] rx, ry;
        int         op;
        logic [2:0] fn;
        rx = ins[9:8];
        ry = ins[7:6];
        op = int'(ins[3:0]);
        if (op >= 8) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else if (op == 0) begin
            exp_q.push_back(mk(1, rx, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        end else if (op == 1) begin
            exp_q.push_back(mk(1, rx, 1, ry, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            fn = 3'(op - 2);
            exp_q.push_back(mk(0, 0,  1, rx, 0, 0,  1, 0, 0, 0, 0,  0));
            exp_q.push_back(mk(0, 0,  0, 0,  1, ry, 0, 1, 0, 0, fn, 0));
            exp_q.push_back(mk(1, rx, 0, 0,  0, 0,  0, 0, 1, 0, fn, 1));
        end
    endtask

    // Drive inputs on the falling edge, advance the model on the rising edge, check after it
    task automatic step(input logic ex, input logic [9:0] ins, input string tag);
        @(negedge CLKb);
        Execute = ex;
        INSTR   = ins;
        @(posedge CLKb);
        if (cur[0] == 1'b0 && Execute) expand(INSTR);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        #1;
        chk(tag, observed(), cur);
        chk({tag, "_bus"}, 18'(Extrn & Gout), '0);
    endtask

    // Asynchronous reset raised between edges and held for n rising edges
    task automatic pulse_reset(input int n);
        #2;
        Reset   = 1'b1;
        Execute = 1'b0;
        exp_q.delete();
        cur = '0;
        #1;
        chk("rst_async", observed(), '0);
        for (int i = 0; i < n; i++) begin
            @(posedge CLKb);
            #1;
            chk("rst_hold", observed(), '0);
        end
        @(negedge CLKb);
        Reset = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        Execute = 1'b0;
        INSTR   = '0;
        cur     = '0;
        #1;
        chk("reset", observed(), '0);
        @(negedge CLKb);
        @(negedge CLKb);
        Reset = 1'b0;

        // LOAD R2
        step(1, 10'b10_00_00_0000, "load_t1");
        step(0, 10'b0, "load_idle");
        // MOV R0,R3
        step(1, 10'b00_11_00_0001, "mov_t1");
        step(0, 10'b0, "mov_idle");
        // SUB R1,R2
        step(1, 10'b01_10_00_0011, "sub_t1");
        step(0, 10'b0, "sub_t2");
        step(0, 10'b0, "sub_t3");
        step(0, 10'b0, "sub_idle");
        // Illegal opcode 1010
        step(1, 10'b11_01_00_1010, "ill_t1");
        step(0, 10'b0, "ill_idle");
        // ADD R1,R1 aborted by reset in T2; no write afterwards
        step(1, 10'b01_01_00_0010, "abort_t1");
        step(0, 10'b0, "abort_t2");
        pulse_reset(2);
        for (int i = 0; i < 4; i++) step(0, 10'b01_01_00_0010, "post_rst");
        // Execute held high, INSTR changes in T2: XOR R3,R0 then LOAD R1
        step(1, 10'b11_00_00_0110, "hold_t1");
        step(1, 10'b01_00_00_0000, "hold_t2");
        step(1, 10'b01_00_00_0000, "hold_t3");
        step(1, 10'b01_00_00_0000, "hold_gap");
        step(1, 10'b01_00_00_0000, "hold_next");
        step(0, 10'b0, "hold_idle");
        // NOT R2 with Rx==Ry
        step(1, 10'b10_10_00_0111, "not_t1");
        step(0, 10'b0, "not_t2");
        step(0, 10'b0, "not_t3");

        // Random instruction stream with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                @(posedge CLKb);
                if (cur[0] == 1'b0 && Execute) expand(INSTR);
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                pulse_reset(int'($urandom_range(1, 2)));
            end else begin
                step(logic'($urandom_range(0, 9) < 6), 10'($urandom), "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
